ysyx_24120009_ifu: RTL
======================

Name: ysyx_24120009_ifu

Overview:
- Instruction fetch unit for the NPC core. Sits directly upstream of the IDU, whose opcode/funct decode is built on the MuxKey selector templates.
- Holds the PC and issues one fetch at a time on a valid/ready instruction-memory interface.
- Presents {pc, inst, fault} to the IDU with a valid/ready handshake.
- Accepts a redirect (branch/jump/trap target) from the EXU/WBU and discards any in-flight fetch it supersedes.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address, always PC with bits [1:0] = 2'b00.
- imem_resp_valid  input  1  response valid; single-cycle pulse, no back-pressure.
- imem_resp_data  input  XLEN  fetched instruction.
- imem_resp_err  input  1  access fault for this response.
- out_valid  output  1  instruction available to the IDU.
- out_ready  input  1  IDU accepts.
- out_pc  output  XLEN  PC of the presented instruction.
- out_inst  output  XLEN  instruction word.
- out_fault  output  1  fetch access fault.
- redirect_valid  input  1  one-cycle redirect pulse.
- redirect_pc  input  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
- perf_fetch_cnt  output  64  instructions delivered (see Optional Feature).
- perf_stall_cnt  output  64  cycles spent in S_WAIT (see Optional Feature).

Behaviour:
- Reset values:
  - pc = RESET_PC, state = S_REQ, drop = 0.
  - imem_req_valid = 1 once out of reset.
  - out_valid = 0, out_pc = 0, out_inst = 0, out_fault = 0.
  - Perf counters = 0.
- Reset mid-operation: all state returns to the reset values immediately; a pending memory response is ignored because imem_resp_valid is only observed in S_WAIT.
- FSM states: S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - imem_req_valid = 1 and imem_req_addr = pc.
  - Memory samples the address only on the handshake, so the address may change while the request is unaccepted.
  - On imem_req_valid && imem_req_ready, go to S_WAIT.
- S_WAIT:
  - imem_req_valid = 0.
  - On imem_resp_valid with drop = 1: clear drop and go to S_REQ; nothing is presented to the IDU.
  - On imem_resp_valid with drop = 0:
    - Register out_pc = pc, out_inst = imem_resp_data and out_fault = imem_resp_err.
    - If imem_resp_err = 1, force out_inst = 0.
    - Set out_valid = 1 and go to S_HOLD.
- S_HOLD:
  - out_valid, out_pc, out_inst and out_fault are held stable until accepted.
  - On out_valid && out_ready: pc <= pc + 4 (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0), out_valid <= 0, go to S_REQ.
- Latency: request handshake in cycle N, response in N+k (k >= 1), out_valid high at N+k+1. Minimum back-to-back throughput is one instruction per 3 cycles.
- Redirect (redirect_valid = 1), required in every state:
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - S_REQ with no handshake this cycle: remain in S_REQ; the new address appears next cycle.
  - S_REQ with handshake this cycle: set drop = 1 and go to S_WAIT.
  - S_WAIT: set drop = 1. If the response arrives in the same cycle, discard it and go to S_REQ with drop = 0.
  - S_HOLD: squash (out_valid <= 0) and go to S_REQ. Redirect has priority over a simultaneous out_ready handshake: pc takes the redirect value, not pc + 4. The IDU must treat a same-cycle redirect as overriding its accept.
- At most one outstanding memory request at any time.
- imem_resp_valid is ignored outside S_WAIT.

Optional Feature:
- Macro: YSYX_24120009_IFU_PERF_EN.
- When defined:
  - perf_fetch_cnt increments on each out_valid && out_ready handshake that is not overridden by a redirect.
  - perf_stall_cnt increments on each cycle spent in S_WAIT.
  - Both are 64-bit, wrap naturally and are cleared by rst.
- When undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package ysyx_24120009_pkg holds:
  - XLEN and RESET_PC defaults.
  - IFU state encoding (S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2).
  - The NOP/zero instruction constant.
- One sub-module: ysyx_24120009_pc_reg, the PC register with async reset to RESET_PC, a load enable, and next-value selection (redirect target vs. pc + 4).

Test Plan:
- Reset release; memory ready = 1 with 1-cycle response of 32'h00000413 -> req_addr = 32'h8000_0000; out_valid at cycle 3 with out_pc = 32'h8000_0000 and out_inst = 32'h00000413; after accept, next req_addr = 32'h8000_0004.
- out_ready held 0 for 5 cycles -> out_* held stable; no new imem request; pc unchanged.
- Redirect to 32'h8000_0102 while in S_WAIT; response arrives 2 cycles later -> response discarded; next req_addr = 32'h8000_0100; only the redirected instruction reaches the IDU.
- Redirect and out_ready in the same cycle in S_HOLD, target 32'h8000_0200 -> out_valid drops; next req_addr = 32'h8000_0200, not pc + 4.
- Response with imem_resp_err = 1 and data 32'hDEADBEEF -> out_fault = 1, out_inst = 0, out_pc = faulting address.
- rst asserted in S_WAIT and the response arrives after release -> response ignored; fetch restarts at 32'h8000_0000. With YSYX_24120009_IFU_PERF_EN defined, perf_fetch_cnt = 0 after reset, and equals 3 after 3 delivered instructions.

Source files
------------

// File: rtl/ysyx_24120009_pkg.sv
// Shared definitions for the NPC fetch path: widths, the reset PC, IFU state encoding
// and the zero instruction that is presented in place of a faulting fetch.
package ysyx_24120009_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] INST_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_t;
endpackage

// File: rtl/ysyx_24120009_pc_reg.sv
// Program counter: async reset to RESET_PC, loads either the word-aligned redirect
// target or the sequential pc + 4 when load is asserted.
module ysyx_24120009_pc_reg
    import ysyx_24120009_pkg::*;
#(
    parameter int              PC_W  = XLEN,
    parameter logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            sel_redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] pc_next;

    // The low two bits of a redirect target are dropped so the PC stays word aligned.
    assign pc_next = sel_redirect ? (redirect_pc & ~PC_W'(3)) : (pc + PC_W'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= PC_RST;
        end else if (load) begin
            pc <= pc_next;
        end
    end
endmodule

// File: rtl/ysyx_24120009_ifu.sv
// Instruction fetch unit: one outstanding imem request, holds the fetched word for the IDU,
// and squashes superseded fetches on redirect. Perf counters need YSYX_24120009_IFU_PERF_EN.
module ysyx_24120009_ifu
    import ysyx_24120009_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt
);
    ifu_state_t      state, state_next;
    logic            drop, drop_next;
    logic            capture, out_clear, pc_load, fetch_fire;
    logic [XLEN-1:0] pc;

    ysyx_24120009_pc_reg #(.PC_W(XLEN), .PC_RST(XLEN'(RESET_PC))) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (pc_load),
        .sel_redirect (redirect_valid),
        .redirect_pc  (redirect_pc),
        .pc           (pc)
    );

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
    assign fetch_fire     = (state == S_HOLD) && out_ready && !redirect_valid;

    // Handshakes: a transfer happens on any rising edge where valid && ready; redirect wins
    // over a same-cycle IDU accept, and drop marks the in-flight response as stale.
    always_comb begin
        state_next = state;
        drop_next  = drop;
        capture    = 1'b0;
        out_clear  = 1'b0;
        pc_load    = redirect_valid;
        case (state)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_next = S_WAIT;
                    if (redirect_valid) drop_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    drop_next = 1'b0;
                    if (drop || redirect_valid) begin
                        state_next = S_REQ;
                    end else begin
                        state_next = S_HOLD;
                        capture    = 1'b1;
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || out_ready) begin
                    state_next = S_REQ;
                    out_clear  = 1'b1;
                    pc_load    = 1'b1;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_REQ;
            drop      <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
            out_fault <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
            if (capture) begin
                out_valid <= 1'b1;
                out_pc    <= pc;
                out_inst  <= imem_resp_err ? XLEN'(INST_ZERO) : imem_resp_data;
                out_fault <= imem_resp_err;
            end else if (out_clear) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef YSYX_24120009_IFU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_fire) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (state == S_WAIT) perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif
endmodule
